// File: rtl/mips_mem_arbiter_if.sv
// Line-transfer bus shared by the cache request ports and the memory port.
// The master drives the request (read/write/addr/wdata); the slave answers
// with rdata and a one-cycle ready pulse.
interface mips_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output read, write, addr, wdata, input  rdata, ready);
  modport slave  (input  read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter sharing one memory line port between the I-cache and
// D-cache miss paths, with a watchdog that aborts unanswered transactions.
module mips_mem_arbiter #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  mips_mem_arbiter_if.slave  i_bus,
  mips_mem_arbiter_if.slave  d_bus,
  mips_mem_arbiter_if.master mem_bus,
  output logic               timeout_err
);
  localparam int unsigned       WDOG_W    = 8;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              req_i, req_d, pick_d, abort;
  logic              last_d_q, last_d_d;   // previous grant went to the D-cache
  logic              win_d_q, win_d_d;     // current transaction belongs to the D-cache
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              terr_q, terr_d;

  assign req_i  = i_bus.read | i_bus.write;
  assign req_d  = d_bus.read | d_bus.write;
  // D wins when alone, or on a tie when I was served last.
  assign pick_d = req_d & (~req_i | ~last_d_q);
  // A memory completion in the last watchdog cycle beats the abort.
  assign abort  = ~mem_bus.ready & (wdog_q == WDOG_LAST);

  assign mem_bus.read  = mem_read_q;
  assign mem_bus.write = mem_write_q;
  assign mem_bus.addr  = mem_addr_q;
  assign mem_bus.wdata = mem_wdata_q;
  assign i_bus.rdata   = i_rdata_q;
  assign i_bus.ready   = i_ready_q;
  assign d_bus.rdata   = d_rdata_q;
  assign d_bus.ready   = d_ready_q;
  assign timeout_err   = terr_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: grant, wait for memory or watchdog, one response cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_i | req_d)          state_d = ST_WAIT;
      ST_WAIT: if (mem_bus.ready | abort)  state_d = ST_RESP;
      ST_RESP:                             state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; ready and timeout pulses default low.
  always_comb begin
    last_d_d    = last_d_q;
    win_d_d     = win_d_q;
    wdog_d      = wdog_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    terr_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i | req_d) begin
          last_d_d    = pick_d;
          win_d_d     = pick_d;
          wdog_d      = '0;
          mem_write_d = pick_d ? d_bus.write : i_bus.write;
          mem_read_d  = ~(pick_d ? d_bus.write : i_bus.write);
          mem_addr_d  = pick_d ? d_bus.addr  : i_bus.addr;
          mem_wdata_d = pick_d ? d_bus.wdata : i_bus.wdata;
        end
      end
      ST_WAIT: begin
        wdog_d = wdog_q + WDOG_W'(1);
        if (mem_bus.ready | abort) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          terr_d      = abort;
          if (win_d_q) d_ready_d = 1'b1;
          else         i_ready_d = 1'b1;
          // Writes keep the old read line unless aborted.
          if (abort) begin
            if (win_d_q) d_rdata_d = '0;
            else         i_rdata_d = '0;
          end else if (!mem_write_q) begin
            if (win_d_q) d_rdata_d = mem_bus.rdata;
            else         i_rdata_d = mem_bus.rdata;
          end
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_q    <= 1'b0;
      win_d_q     <= 1'b0;
      wdog_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      last_d_q    <= last_d_d;
      win_d_q     <= win_d_d;
      wdog_q      <= wdog_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      terr_q      <= terr_d;
    end
  end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: transaction-level model plus directed scenarios.
`timescale 1ns/1ps
module tb_mips_mem_arbiter;
  localparam int unsigned ADDR_W  = 28;
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;
  logic timeout_err;

  mips_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) i_bus ();
  mips_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) d_bus ();
  mips_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  mips_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_bus      (i_bus),
    .d_bus      (d_bus),
    .mem_bus    (mem_bus),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string nm, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_d(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Cycle counter used to schedule spurious memory pulses.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: answers after mem_lat strobed cycles (0 = never), plus
  // an optional spurious ready pulse at cycle spur_at.
  int unsigned       mem_lat    = 0;
  int unsigned       spur_at    = 32'hFFFF_FFFF;
  int unsigned       strobe_cnt = 0;
  logic [DATA_W-1:0] rd_base    = '0;
  bit                rd_mix     = 1'b0;
  localparam logic [DATA_W-1:0] SPUR_DATA = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      mem_bus.ready = 1'b0;
      mem_bus.rdata = '0;
      strobe_cnt    = 0;
    end else begin
      mem_bus.ready = 1'b0;
      if (cyc == spur_at) begin
        mem_bus.ready = 1'b1;
        mem_bus.rdata = SPUR_DATA;
      end else if (mem_bus.read || mem_bus.write) begin
        strobe_cnt++;
        if (mem_lat != 0 && strobe_cnt == mem_lat) begin
          mem_bus.ready = 1'b1;
          mem_bus.rdata = rd_mix ? (rd_base ^ DATA_W'(mem_bus.addr)) : rd_base;
        end
      end else begin
        strobe_cnt = 0;
      end
    end
  end

  // Transaction model: a free port takes the round-robin winner, the
  // transaction lives until memory answers or TIMEOUT strobed cycles pass,
  // then one response cycle is spent before the port is free again.
  localparam int PH_FREE = 0;
  localparam int PH_MEM  = 1;
  localparam int PH_RESP = 2;
  int                m_phase  = PH_FREE;
  bit                m_last_d = 1'b0;
  bit                m_on_d   = 1'b0;
  bit                m_wr     = 1'b0;
  int unsigned       m_age    = 0;
  logic              exp_mr = 1'b0, exp_mw = 1'b0, exp_ir = 1'b0, exp_dr = 1'b0, exp_te = 1'b0;
  logic [ADDR_W-1:0] exp_ma  = '0;
  logic [DATA_W-1:0] exp_mwd = '0, exp_ird = '0, exp_drd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = PH_FREE; m_last_d = 1'b0; m_on_d = 1'b0; m_wr = 1'b0; m_age = 0;
      exp_mr = 1'b0; exp_mw = 1'b0; exp_ir = 1'b0; exp_dr = 1'b0; exp_te = 1'b0;
      exp_ma = '0; exp_mwd = '0; exp_ird = '0; exp_drd = '0;
    end else begin
      case (m_phase)
        PH_FREE: begin
          if (i_bus.read || i_bus.write || d_bus.read || d_bus.write) begin
            m_on_d   = (d_bus.read || d_bus.write) &&
                       (!(i_bus.read || i_bus.write) || !m_last_d);
            m_last_d = m_on_d;
            m_wr     = m_on_d ? d_bus.write : i_bus.write;
            exp_ma   = m_on_d ? d_bus.addr  : i_bus.addr;
            exp_mwd  = m_on_d ? d_bus.wdata : i_bus.wdata;
            exp_mr   = !m_wr;
            exp_mw   = m_wr;
            m_age    = 0;
            m_phase  = PH_MEM;
          end
        end
        PH_MEM: begin
          m_age++;
          if (mem_bus.ready || m_age == TIMEOUT) begin
            exp_mr = 1'b0;
            exp_mw = 1'b0;
            exp_te = !mem_bus.ready;
            if (m_on_d) begin
              exp_dr = 1'b1;
              if (!mem_bus.ready) exp_drd = '0;
              else if (!m_wr)     exp_drd = mem_bus.rdata;
            end else begin
              exp_ir = 1'b1;
              if (!mem_bus.ready) exp_ird = '0;
              else if (!m_wr)     exp_ird = mem_bus.rdata;
            end
            m_phase = PH_RESP;
          end
        end
        default: begin
          exp_ir = 1'b0; exp_dr = 1'b0; exp_te = 1'b0;
          m_phase = PH_FREE;
        end
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk_b("cmp_mem_read",  mem_bus.read,  exp_mr);
      chk_b("cmp_mem_write", mem_bus.write, exp_mw);
      chk_a("cmp_mem_addr",  mem_bus.addr,  exp_ma);
      chk_d("cmp_mem_wdata", mem_bus.wdata, exp_mwd);
      chk_b("cmp_i_ready",   i_bus.ready,   exp_ir);
      chk_b("cmp_d_ready",   d_bus.ready,   exp_dr);
      chk_d("cmp_i_rdata",   i_bus.rdata,   exp_ird);
      chk_d("cmp_d_rdata",   d_bus.rdata,   exp_drd);
      chk_b("cmp_timeout",   timeout_err,   exp_te);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench time limit");
  end

  task automatic all_zero(input string tag);
    chk_b({tag, "_mem_read"},  mem_bus.read,  1'b0);
    chk_b({tag, "_mem_write"}, mem_bus.write, 1'b0);
    chk_a({tag, "_mem_addr"},  mem_bus.addr,  '0);
    chk_d({tag, "_mem_wdata"}, mem_bus.wdata, '0);
    chk_b({tag, "_i_ready"},   i_bus.ready,   1'b0);
    chk_b({tag, "_d_ready"},   d_bus.ready,   1'b0);
    chk_d({tag, "_i_rdata"},   i_bus.rdata,   '0);
    chk_d({tag, "_d_rdata"},   d_bus.rdata,   '0);
    chk_b({tag, "_timeout"},   timeout_err,   1'b0);
  endtask

  int got;
  bit order [0:3];

  initial begin
    rst = 1'b1;
    i_bus.read = 1'b0; i_bus.write = 1'b0; i_bus.addr = '0; i_bus.wdata = '0;
    d_bus.read = 1'b0; d_bus.write = 1'b0; d_bus.addr = '0; d_bus.wdata = '0;
    repeat (3) @(negedge clk);
    all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Lone I read, memory answers on the third strobed cycle.
    mem_lat = 3; rd_base = {16{8'hA5}}; rd_mix = 1'b0;
    i_bus.read = 1'b1; i_bus.addr = 28'h0000010;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk_b("t2_mem_read", mem_bus.read, 1'b1);
      chk_a("t2_mem_addr", mem_bus.addr, 28'h0000010);
      chk_b("t2_i_ready_early", i_bus.ready, 1'b0);
      chk_b("t2_d_ready", d_bus.ready, 1'b0);
    end
    @(negedge clk);
    chk_b("t2_i_ready", i_bus.ready, 1'b1);
    chk_d("t2_i_rdata", i_bus.rdata, {16{8'hA5}});
    chk_b("t2_mem_read_drop", mem_bus.read, 1'b0);
    chk_b("t2_d_ready_idle", d_bus.ready, 1'b0);
    i_bus.read = 1'b0;
    @(negedge clk);
    chk_b("t2_i_ready_pulse", i_bus.ready, 1'b0);
    chk_d("t2_i_rdata_hold", i_bus.rdata, {16{8'hA5}});

    // D writeback.
    mem_lat = 2;
    d_bus.write = 1'b1; d_bus.addr = 28'h0ABCDEF;
    d_bus.wdata = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    @(negedge clk);
    chk_b("t4_mem_write", mem_bus.write, 1'b1);
    chk_b("t4_mem_read",  mem_bus.read,  1'b0);
    chk_a("t4_mem_addr",  mem_bus.addr,  28'h0ABCDEF);
    chk_d("t4_mem_wdata", mem_bus.wdata, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
    @(negedge clk);
    chk_b("t4_d_ready_early", d_bus.ready, 1'b0);
    @(negedge clk);
    chk_b("t4_d_ready", d_bus.ready, 1'b1);
    chk_b("t4_mem_write_drop", mem_bus.write, 1'b0);
    chk_d("t4_d_rdata_kept", d_bus.rdata, '0);
    d_bus.write = 1'b0;
    @(negedge clk);

    // Silent memory: abort after TIMEOUT strobed cycles.
    mem_lat = 0;
    i_bus.read = 1'b1; i_bus.addr = 28'h0000022;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk_b("t5_strobe", mem_bus.read, 1'b1);
      chk_b("t5_no_timeout_yet", timeout_err, 1'b0);
    end
    @(negedge clk);
    chk_b("t5_strobe_drop", mem_bus.read, 1'b0);
    chk_b("t5_i_ready", i_bus.ready, 1'b1);
    chk_b("t5_timeout", timeout_err, 1'b1);
    chk_d("t5_i_rdata_zero", i_bus.rdata, '0);
    i_bus.read = 1'b0;
    @(negedge clk);
    chk_b("t5_timeout_pulse", timeout_err, 1'b0);

    // Memory answers in the final watchdog cycle: completion wins.
    mem_lat = 4; rd_base = {4{32'hC0FFEE11}};
    d_bus.read = 1'b1; d_bus.addr = 28'h0000033;
    repeat (4) @(negedge clk);
    @(negedge clk);
    chk_b("t5b_d_ready", d_bus.ready, 1'b1);
    chk_b("t5b_no_timeout", timeout_err, 1'b0);
    chk_d("t5b_d_rdata", d_bus.rdata, {4{32'hC0FFEE11}});
    d_bus.read = 1'b0;
    @(negedge clk);

    // Spurious mem_ready while idle.
    spur_at = cyc + 1;
    repeat (3) begin
      @(negedge clk);
      chk_b("t6_idle_i_ready", i_bus.ready, 1'b0);
      chk_b("t6_idle_d_ready", d_bus.ready, 1'b0);
      chk_d("t6_idle_d_rdata", d_bus.rdata, {4{32'hC0FFEE11}});
    end

    // Spurious mem_ready during the response cycle.
    mem_lat = 1; rd_base = {16{8'h3C}};
    i_bus.read = 1'b1; i_bus.addr = 28'h0000044;
    spur_at = cyc + 2;
    @(negedge clk);
    @(negedge clk);
    chk_b("t6_resp_i_ready", i_bus.ready, 1'b1);
    chk_d("t6_resp_i_rdata", i_bus.rdata, {16{8'h3C}});
    i_bus.read = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_b("t6_after_i_ready", i_bus.ready, 1'b0);
      chk_b("t6_after_mem_read", mem_bus.read, 1'b0);
      chk_d("t6_after_i_rdata", i_bus.rdata, {16{8'h3C}});
    end

    // Reset in the middle of a transaction.
    mem_lat = 0;
    i_bus.read = 1'b1; i_bus.addr = 28'h0000055;
    repeat (2) @(negedge clk);
    chk_b("t1_in_wait", mem_bus.read, 1'b1);
    rst = 1'b1;
    #1;
    all_zero("t1_rst");

    // Both request continuously after reset: D, I, D, I.
    d_bus.read = 1'b1; d_bus.addr = 28'h0000100;
    i_bus.addr = 28'h0000200;
    mem_lat = 2; rd_base = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0; rd_mix = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_b("t1_first_read", mem_bus.read, 1'b1);
    chk_a("t1_first_addr", mem_bus.addr, 28'h0000100);
    got = 0;
    for (int c = 0; c < 80 && got < 4; c++) begin
      @(negedge clk);
      if (d_bus.ready) begin
        order[got] = 1'b1; got++;
        d_bus.addr = d_bus.addr + 28'd1;
      end else if (i_bus.ready) begin
        order[got] = 1'b0; got++;
        i_bus.addr = i_bus.addr + 28'd1;
      end
    end
    i_bus.read = 1'b0; d_bus.read = 1'b0;
    chk_i("t3_grant_count", got, 4);
    chk_b("t3_order0", order[0], 1'b1);
    chk_b("t3_order1", order[1], 1'b0);
    chk_b("t3_order2", order[2], 1'b1);
    chk_b("t3_order3", order[3], 1'b0);
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
